// File: rtl/tc_io_pkg.sv
// Shared widths and depths for the tiny-computer I/O port.
// The core's register width and the per-direction FIFO depth are defined here.
package tc_io_pkg;

    localparam int TC_IO_WIDTH      = 32;
    localparam int TC_IO_DEPTH_LOG2 = 3;
    localparam int DEPTH            = 1 << TC_IO_DEPTH_LOG2;

endpackage

// File: rtl/tc_io_fifo.sv
// Pointer-based single-clock FIFO with full/empty flags and a head output
// that reads zero whenever the FIFO holds nothing.
module tc_io_fifo
    import tc_io_pkg::*;
#(
    parameter int WIDTH      = TC_IO_WIDTH,
    parameter int DEPTH_LOG2 = TC_IO_DEPTH_LOG2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int ENTRIES = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]    mem [ENTRIES];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;

    // The extra pointer MSB separates the full case from the empty case.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
        end
    end

    // Head is a pure function of registered pointers and storage, so it stays
    // stable across the whole core instruction cycle.
    assign head = empty ? '0 : mem[rd_ptr[DEPTH_LOG2-1:0]];

endmodule

// File: rtl/tc_io_port.sv
// I/O responder beside the tiny-computer core: a host-to-core input FIFO and a
// core-to-host output FIFO, plus sticky underflow/overflow flags.
module tc_io_port
    import tc_io_pkg::*;
#(
    parameter int WIDTH      = TC_IO_WIDTH,
    parameter int DEPTH_LOG2 = TC_IO_DEPTH_LOG2
) (
    input  logic             Ph0,
    input  logic             Reset,
    output logic [WIDTH-1:0] InData,
    output logic             InRdy,
    input  logic             InStrobe,
    input  logic             OutStrobe,
    input  logic [WIDTH-1:0] OutData,
    input  logic [WIDTH-1:0] HostInData,
    input  logic             HostInValid,
    output logic             HostInReady,
    output logic [WIDTH-1:0] HostOutData,
    output logic             HostOutValid,
    input  logic             HostOutReady,
    output logic             InUnderflow,
    output logic             OutOverflow,
    input  logic             ClearErr
);

    logic in_empty;
    logic in_full;
    logic in_push;
    logic in_pop;
    logic out_empty;
    logic out_full;
    logic out_push;
    logic out_pop;

    // A full input FIFO still takes a host word when the core pops the head
    // on the same edge, so a streaming host never loses a slot.
    assign HostInReady = (~in_full | InStrobe) & ~Reset;
    assign in_push     = HostInValid & HostInReady;
    assign in_pop      = InStrobe & ~in_empty;
    assign InRdy       = ~in_empty;

    tc_io_fifo #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) in_fifo (
        .clk     (Ph0),
        .reset   (Reset),
        .push    (in_push),
        .pop     (in_pop),
        .wr_data (HostInData),
        .head    (InData),
        .empty   (in_empty),
        .full    (in_full)
    );

    // Output side uses pre-edge fullness, so a host pop cannot make room
    // for a word strobed on that same edge.
    assign out_push     = OutStrobe & ~out_full;
    assign out_pop      = HostOutValid & HostOutReady;
    assign HostOutValid = ~out_empty;

    tc_io_fifo #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) out_fifo (
        .clk     (Ph0),
        .reset   (Reset),
        .push    (out_push),
        .pop     (out_pop),
        .wr_data (OutData),
        .head    (HostOutData),
        .empty   (out_empty),
        .full    (out_full)
    );

    // A fresh error event outranks ClearErr on the same edge.
    always_ff @(posedge Ph0) begin
        if (Reset) begin
            InUnderflow <= 1'b0;
            OutOverflow <= 1'b0;
        end else begin
            if (InStrobe && in_empty) begin
                InUnderflow <= 1'b1;
            end else if (ClearErr) begin
                InUnderflow <= 1'b0;
            end
            if (OutStrobe && out_full) begin
                OutOverflow <= 1'b1;
            end else if (ClearErr) begin
                OutOverflow <= 1'b0;
            end
        end
    end

endmodule
